// File: rtl/alu_issue_stage.sv
// Operand fetch/issue ahead of an 8-bit ALU: IDLE -> EXEC -> WB, 3 cycles per instruction (2 when illegal).
// Backpressure: in_ready is high only in IDLE; upstream holds instr until it is accepted.
module alu_issue_stage #(
    parameter int NREG  = 8,
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    output logic [DW-1:0]    SrcA,
    output logic [15:0]      SrcB,
    output logic [2:0]       control,
    input  logic [DW-1:0]    alu_result,
    input  logic             alu_z,
    output logic             z_flag,
    output logic             done,
    output logic             illegal,
    input  logic [2:0]       dbg_addr,
    output logic [DW-1:0]    dbg_data,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_regs [NREG];
    logic [DW-1:0]    r_srca;
    logic [15:0]      r_srcb;
    logic [2:0]       r_ctrl;
    logic [2:0]       r_rd;
    logic             r_illegal;
    logic [DW-1:0]    r_result;
    logic             r_z;
    logic [CNT_W-1:0] r_retired;

    logic [3:0]       w_op;
    logic [2:0]       w_rd;
    logic [2:0]       w_rs;
    logic [2:0]       w_rt;
    logic [4:0]       w_shamt;
    logic [7:0]       w_imm;
    logic             w_illegal;
    logic [2:0]       w_ctrl;
    logic [DW-1:0]    w_srca;
    logic [15:0]      w_srcb;
    logic             w_accept;
    logic             w_wb_write;

    assign w_op     = instr[15:12];
    assign w_rd     = instr[11:9];
    assign w_rs     = instr[8:6];
    assign w_rt     = instr[5:3];
    assign w_shamt  = instr[4:0];
    assign w_imm    = instr[7:0];
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Operands come straight from the register file, so a dependent
    // instruction accepted after WB already sees the written value.
    always_comb begin
        w_illegal = 1'b0;
        w_ctrl    = w_op[2:0];
        w_srca    = r_regs[w_rs];
        w_srcb    = {{(16-DW){1'b0}}, r_regs[w_rt]};
        case (w_op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7: begin
            end
            4'd3: begin
                w_srcb = {5'b0, w_shamt, 6'b0};
            end
            4'd8, 4'd9, 4'd10, 4'd14, 4'd15: begin
                w_srca = r_regs[w_rd];
                w_srcb = {8'h00, w_imm};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_illegal ? S_WB : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
            end
            S_WB: begin
                done        = 1'b1;
                illegal     = r_illegal;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_srca    <= '0;
            r_srcb    <= '0;
            r_ctrl    <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_z       <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_accept) begin
                r_srca    <= w_srca;
                r_srcb    <= w_srcb;
                r_ctrl    <= w_ctrl;
                r_rd      <= w_rd;
                r_illegal <= w_illegal;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result;
                r_z      <= alu_z;
            end
            if ((r_state == S_WB) && !r_illegal) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // r0 is never written, so it keeps its reset value of zero.
    assign w_wb_write = (r_state == S_WB) && !r_illegal && (r_rd != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[r_rd] <= r_result;
        end
    end

    assign SrcA     = r_srca;
    assign SrcB     = r_srcb;
    assign control  = r_ctrl;
    assign z_flag   = r_z;
    assign retired  = r_retired;
    assign dbg_data = r_regs[dbg_addr];

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-fetch/issue stage directly upstream of the 8-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake, decodes opcode to the ALU's 3-bit control, and reads an 8x8 register file.
- Drives SrcA/SrcB/control for one EXEC cycle, captures the ALU result and zero flag, then writes the result back to the register file.
- Non-pipelined 3-cycle sequencer: IDLE -> EXEC -> WB.

Parameters:
- NREG, 8, number of registers; r0 reads as 0.
- DW, 8, data width; must match the ALU width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  high only in IDLE
- instr  in  16  instruction word, sampled on accept
- SrcA  out  8  ALU operand A
- SrcB  out  16  ALU operand B, including the shift-amount field
- control  out  3  ALU operation select
- alu_result  in  8  ALU result
- alu_z  in  1  ALU zero flag
- z_flag  out  1  registered zero flag of the last executed instruction
- done  out  1  one-cycle pulse in WB
- illegal  out  1  valid with done; high for an undefined opcode
- dbg_addr  in  3  debug register-read address
- dbg_data  out  8  combinational read of reg[dbg_addr]
- retired  out  CNT_W  count of legal instructions written back

Behaviour:
- Reset (async, active-low):
  - State IDLE.
  - All registers, SrcA, SrcB, control, z_flag, done, illegal and retired = 0.
  - in_ready = 1 once rst_n is deasserted.
- Instruction format:
  - [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [4:0] shamt, [7:0] imm8.
- Opcode decode:
  - R-type op 0/1/2/6/7: control = op[2:0]; SrcA = reg[rs]; SrcB = {8'h00, reg[rt]}.
  - Shift op 3: control = 3; SrcA = reg[rs]; SrcB = {5'b0, shamt, 6'b0}, so shamt occupies SrcB[10:6].
  - I-type op 8/9/10/14/15: control = op[2:0]; SrcA = reg[rd]; SrcB = {8'h00, imm8}.
  - Ops 4, 5, 11, 12 and 13 are illegal.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch rd, compute operands from the current register contents, and register SrcA/SrcB/control.
  - Legal opcode -> EXEC; illegal opcode -> WB with the illegal flag set.
  - in_valid low: stay in IDLE.
- EXEC (1 cycle):
  - SrcA/SrcB/control are stable for the whole cycle.
  - At the closing edge: capture alu_result into a result register and alu_z into z_flag.
  - -> WB.
- WB (1 cycle):
  - done = 1; illegal = the decoded flag.
  - Legal instruction: write reg[rd] <- result at the closing edge, unless rd = 0, in which case the write is discarded; retired += 1.
  - Illegal instruction: no register write, z_flag unchanged, retired unchanged.
  - -> IDLE.
- Timing:
  - Accept at edge T; EXEC is cycle T+1; WB is cycle T+2; in_ready is high again in cycle T+3.
  - Throughput is one instruction per 3 cycles.
  - The written value is visible on dbg_data from cycle T+3.
- Output hold:
  - SrcA/SrcB/control hold their values outside EXEC and change only on accept.
  - done and illegal are 0 outside WB.
- Read-after-write: back-to-back dependent instructions read the updated value because operands are sampled after the previous WB edge. No forwarding is required.
- Counter: retired wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: immediate abort to IDLE; the pending write is discarded and all registers clear.
- Unused inputs: alu_result/alu_z are ignored outside EXEC. in_valid is ignored outside IDLE; upstream must hold the instruction until it is accepted.

Test Plan:
- Reset then ADDI r1, 0x05 (instr 0xA205):
  - Cycle T+1: SrcA=0, SrcB=0x0005, control=2.
  - With the ALU connected: done in T+2, dbg_addr=1 reads 0x05, retired=1, z_flag=0.
- SUB equal operands, with r1=r2=0x05:
  - SUB r3, r1, r2 (0x6650): z_flag=1, reg3=0x00, done pulses exactly one cycle.
- Shift:
  - r1=0x80, SRL r4, r1, 3 (0x3843): SrcB=0x00C0 (shamt in bits [10:6]), control=3.
  - reg4=0x10 after WB.
- Illegal opcode 0x4xxx:
  - Accepted; WB one cycle after accept with done=1 and illegal=1.
  - No register changes, retired unchanged, in_ready high one cycle earlier than for a legal op.
- Write to r0 and back-to-back dependency:
  - ADDI r0, 0xFF leaves r0 reading 0.
  - ADDI r2, 0x01 followed immediately by ADD r2, r2, r2 yields r2=0x02.
  - in_valid held high throughout: accepts every 3rd cycle only.
- Reset mid-EXEC:
  - rst_n low during EXEC of ADDI r5, 0x33: r5 stays 0, state returns to IDLE, done never pulses, retired=0.
